csr_file: RTL and testbench

- Architectural CSR state holder that sits directly downstream of the combinational CSR access unit.
- Consumes committed CSR writes (the unit's write_en/write_value), trap entry/return events, retire pulses and external IRQ lines.
- Drives the csr_* read buses that feed back into the CSR access unit, plus a registered interrupt request to the fetch/trap logic.
- Owns the privilege register, the cycle/instret/timer counters and the sticky IRQ-pending latch.

---
 rtl/csr_file.sv | 250 +++++++++++++++++++++++++
 tb/tb_csr_file.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// -----------------------------------------------------------------------------
// csr_file
//
// Architectural CSR state holder sitting downstream of the combinational CSR
// access unit. It takes committed CSR writes, trap entry/return events, retire
// pulses and external level interrupt lines. It drives the csr_* read buses
// back into the access unit and a registered interrupt request to fetch/trap.
//
// Optional feature macro: AMBER_CSR_TIMER_EN
//   defined   -> timer, timer_cmp and the timer-compare pending set exist
//   undefined -> csr_timer / csr_timer_cmp read 0, writes to C02/C03 ignored
//
// Ports
//   clk, rst          core clock, asynchronous active-high reset
//   wr_en/addr/data   committed CSR write (dropped on trap entry)
//   trap_valid        trap entry: saves trap_pc/trap_cause, enters priv 1
//   trap_ret          return from trap (trap_valid has priority)
//   instret_inc       one instruction retired this cycle
//   irq_lines         external level interrupt lines
//   cur_priv          current privilege level
//   csr_*             architectural CSR read buses
//   irq_req, irq_id   registered interrupt request / lowest active line
//
// CSR map
//   000 status   001 scratch  002 epc      003 cause    004 lr   005 ssp
//   010 irq_enable            011 irq_pending           012 irq_vector
//   C00 cycle    C01 instret  C02 timer    C03 timer_cmp
//
// Status layout: [1:0] mirror cur_priv (not writable), [2] IE, [3] PIE,
// [5:4] PPRIV, remaining bits plain storage.
// -----------------------------------------------------------------------------
module csr_file #(
    parameter logic [47:0] IRQ_LINE_MASK = 48'd0,
    parameter int unsigned TIMER_IRQ_BIT = 47,
    parameter logic [47:0] RESET_VECTOR  = 48'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [47:0] wr_data,
    input  logic        trap_valid,
    input  logic [47:0] trap_pc,
    input  logic [47:0] trap_cause,
    input  logic        trap_ret,
    input  logic        instret_inc,
    input  logic [47:0] irq_lines,
    output logic [1:0]  cur_priv,
    output logic [47:0] csr_status,
    output logic [47:0] csr_scratch,
    output logic [47:0] csr_epc,
    output logic [47:0] csr_cause,
    output logic [47:0] csr_lr,
    output logic [47:0] csr_ssp,
    output logic [47:0] csr_irq_enable,
    output logic [47:0] csr_irq_pending,
    output logic [47:0] csr_irq_vector,
    output logic [47:0] csr_cycle,
    output logic [47:0] csr_instret,
    output logic [47:0] csr_timer,
    output logic [47:0] csr_timer_cmp,
    output logic        irq_req,
    output logic [5:0]  irq_id
);

    localparam logic [11:0] A_STATUS  = 12'h000;
    localparam logic [11:0] A_SCRATCH = 12'h001;
    localparam logic [11:0] A_EPC     = 12'h002;
    localparam logic [11:0] A_CAUSE   = 12'h003;
    localparam logic [11:0] A_LR      = 12'h004;
    localparam logic [11:0] A_SSP     = 12'h005;
    localparam logic [11:0] A_IRQ_EN  = 12'h010;
    localparam logic [11:0] A_IRQ_PND = 12'h011;
    localparam logic [11:0] A_IRQ_VEC = 12'h012;
    localparam logic [11:0] A_CYCLE   = 12'hC00;
    localparam logic [11:0] A_INSTRET = 12'hC01;
    localparam logic [11:0] A_TIMER   = 12'hC02;
    localparam logic [11:0] A_TCMP    = 12'hC03;

    localparam logic [1:0] PRIV_MACHINE = 2'd3;
    localparam logic [1:0] PRIV_TRAP    = 2'd1;

    // Status bits [1:0] are never stored; they always reflect r_priv.
    logic [1:0]  r_priv;
    logic [47:2] r_status;
    logic [47:0] r_scratch, r_epc, r_cause, r_lr, r_ssp;
    logic [47:0] r_irq_enable, r_irq_pending, r_irq_vector;
    logic [47:0] r_cycle, r_instret;
    logic        r_irq_req;
    logic [5:0]  r_irq_id;

    logic        w_wr_ok;
    logic        w_wr_status;
    logic [1:0]  w_priv_next;
    logic [47:2] w_status_next;
    logic [47:0] w_timer, w_timer_cmp;
    logic        w_timer_hit;
    logic [47:0] w_timer_set;
    logic [47:0] w_pend_base, w_pend_next;
    logic [47:0] w_irq_active;
    logic [5:0]  w_irq_id;

    // Trap entry drops every write; trap return drops only a status write,
    // because status is being rewritten by the return itself.
    assign w_wr_ok     = wr_en & ~trap_valid;
    assign w_wr_status = w_wr_ok & ~trap_ret & (wr_addr == A_STATUS);

    // -------------------------------------------------------------------------
    // Privilege / status next-state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_priv_next   = r_priv;
        w_status_next = r_status;
        if (trap_valid) begin
            w_status_next[3]   = r_status[2];
            w_status_next[2]   = 1'b0;
            w_status_next[5:4] = r_priv;
            w_priv_next        = PRIV_TRAP;
        end else if (trap_ret) begin
            w_status_next[2]   = r_status[3];
            w_status_next[3]   = 1'b1;
            w_priv_next        = r_status[5:4];
            w_status_next[5:4] = 2'd0;
        end else if (w_wr_status) begin
            w_status_next = wr_data[47:2];
        end
    end

    // -------------------------------------------------------------------------
    // Optional timer
    // -------------------------------------------------------------------------
`ifdef AMBER_CSR_TIMER_EN
    logic [47:0] r_timer, r_timer_cmp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer     <= '0;
            r_timer_cmp <= '0;
        end else begin
            if (w_wr_ok && wr_addr == A_TIMER) r_timer <= wr_data;
            else                               r_timer <= r_timer + 48'd1;
            if (w_wr_ok && wr_addr == A_TCMP)  r_timer_cmp <= wr_data;
        end
    end

    assign w_timer     = r_timer;
    assign w_timer_cmp = r_timer_cmp;
    // A zero compare value disarms the timer interrupt.
    assign w_timer_hit = (r_timer == r_timer_cmp) && (r_timer_cmp != '0);
`else
    assign w_timer     = '0;
    assign w_timer_cmp = '0;
    assign w_timer_hit = 1'b0;
`endif

    assign w_timer_set = {47'd0, w_timer_hit} << TIMER_IRQ_BIT;

    // -------------------------------------------------------------------------
    // Pending: hardware sets are ORed after the software value, so a line or
    // timer hit wins over a software clear in the same cycle.
    // -------------------------------------------------------------------------
    assign w_pend_base = (w_wr_ok && wr_addr == A_IRQ_PND) ? wr_data : r_irq_pending;
    assign w_pend_next = (w_pend_base | irq_lines | w_timer_set) & IRQ_LINE_MASK;

    assign w_irq_active = r_irq_pending & r_irq_enable;

    // Scan from the top so the last hit, the lowest index, is kept.
    always_comb begin
        w_irq_id = '0;
        for (int i = 47; i >= 0; i--) begin
            if (w_irq_active[i]) w_irq_id = 6'(i);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_priv        <= PRIV_MACHINE;
            r_status      <= '0;
            r_scratch     <= '0;
            r_epc         <= '0;
            r_cause       <= '0;
            r_lr          <= '0;
            r_ssp         <= '0;
            r_irq_enable  <= '0;
            r_irq_pending <= '0;
            r_irq_vector  <= RESET_VECTOR;
            r_cycle       <= '0;
            r_instret     <= '0;
            r_irq_req     <= 1'b0;
            r_irq_id      <= '0;
        end else begin
            r_priv        <= w_priv_next;
            r_status      <= w_status_next;
            r_irq_pending <= w_pend_next;

            if (trap_valid) begin
                r_epc   <= trap_pc;
                r_cause <= trap_cause;
            end else if (w_wr_ok) begin
                if (wr_addr == A_EPC)   r_epc   <= wr_data;
                if (wr_addr == A_CAUSE) r_cause <= wr_data;
            end

            if (w_wr_ok && wr_addr == A_SCRATCH) r_scratch    <= wr_data;
            if (w_wr_ok && wr_addr == A_LR)      r_lr         <= wr_data;
            if (w_wr_ok && wr_addr == A_SSP)     r_ssp        <= wr_data;
            if (w_wr_ok && wr_addr == A_IRQ_EN)  r_irq_enable <= wr_data & IRQ_LINE_MASK;
            if (w_wr_ok && wr_addr == A_IRQ_VEC) r_irq_vector <= wr_data;

            // A same-cycle write to a counter replaces the increment.
            if (w_wr_ok && wr_addr == A_CYCLE)   r_cycle <= wr_data;
            else                                 r_cycle <= r_cycle + 48'd1;
            if (w_wr_ok && wr_addr == A_INSTRET) r_instret <= wr_data;
            else                                 r_instret <= r_instret + {47'd0, instret_inc};

            // Built from registered state, so it lags the pending/IE update
            // by one cycle.
            r_irq_req <= r_status[2] & (|w_irq_active);
            r_irq_id  <= w_irq_id;
        end
    end

    // -------------------------------------------------------------------------
    // Read buses
    // -------------------------------------------------------------------------
    assign cur_priv        = r_priv;
    assign csr_status      = {r_status, r_priv};
    assign csr_scratch     = r_scratch;
    assign csr_epc         = r_epc;
    assign csr_cause       = r_cause;
    assign csr_lr          = r_lr;
    assign csr_ssp         = r_ssp;
    assign csr_irq_enable  = r_irq_enable;
    assign csr_irq_pending = r_irq_pending;
    assign csr_irq_vector  = r_irq_vector;
    assign csr_cycle       = r_cycle;
    assign csr_instret     = r_instret;
    assign csr_timer       = w_timer;
    assign csr_timer_cmp   = w_timer_cmp;
    assign irq_req         = r_irq_req;
    assign irq_id          = r_irq_id;

endmodule

// File: tb/tb_csr_file.sv
// -----------------------------------------------------------------------------
// tb_csr_file
//
// Directed bench for csr_file. Stimulus pushes expected values, tagged with the
// cycle they must appear on, into a scoreboard queue; an independent monitor
// compares them on the falling edge of that cycle.
// Expected timer behaviour follows AMBER_CSR_TIMER_EN as seen by this build.
// -----------------------------------------------------------------------------
module tb_csr_file;

    localparam logic [47:0] MASK = 48'h0F;
    localparam int unsigned TBIT = 3;
    localparam logic [47:0] RVEC = 48'h0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [47:0] wr_data;
    logic        trap_valid;
    logic [47:0] trap_pc;
    logic [47:0] trap_cause;
    logic        trap_ret;
    logic        instret_inc;
    logic [47:0] irq_lines;
    logic [1:0]  cur_priv;
    logic [47:0] csr_status, csr_scratch, csr_epc, csr_cause, csr_lr, csr_ssp;
    logic [47:0] csr_irq_enable, csr_irq_pending, csr_irq_vector;
    logic [47:0] csr_cycle, csr_instret, csr_timer, csr_timer_cmp;
    logic        irq_req;
    logic [5:0]  irq_id;

    csr_file #(
        .IRQ_LINE_MASK(MASK),
        .TIMER_IRQ_BIT(TBIT),
        .RESET_VECTOR (RVEC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .trap_cause     (trap_cause),
        .trap_ret       (trap_ret),
        .instret_inc    (instret_inc),
        .irq_lines      (irq_lines),
        .cur_priv       (cur_priv),
        .csr_status     (csr_status),
        .csr_scratch    (csr_scratch),
        .csr_epc        (csr_epc),
        .csr_cause      (csr_cause),
        .csr_lr         (csr_lr),
        .csr_ssp        (csr_ssp),
        .csr_irq_enable (csr_irq_enable),
        .csr_irq_pending(csr_irq_pending),
        .csr_irq_vector (csr_irq_vector),
        .csr_cycle      (csr_cycle),
        .csr_instret    (csr_instret),
        .csr_timer      (csr_timer),
        .csr_timer_cmp  (csr_timer_cmp),
        .irq_req        (irq_req),
        .irq_id         (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release; held at 0 while reset is asserted.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef enum {
        S_PRIV, S_STATUS, S_SCRATCH, S_EPC, S_CAUSE, S_LR, S_SSP,
        S_EN, S_PEND, S_VEC, S_CYCLE, S_INSTRET, S_TIMER, S_TCMP,
        S_IRQ_REQ, S_IRQ_ID
    } sel_t;

    typedef struct {
        int          due;
        sel_t        sel;
        logic [47:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [47:0] peek(sel_t s);
        case (s)
            S_PRIV:    return {46'd0, cur_priv};
            S_STATUS:  return csr_status;
            S_SCRATCH: return csr_scratch;
            S_EPC:     return csr_epc;
            S_CAUSE:   return csr_cause;
            S_LR:      return csr_lr;
            S_SSP:     return csr_ssp;
            S_EN:      return csr_irq_enable;
            S_PEND:    return csr_irq_pending;
            S_VEC:     return csr_irq_vector;
            S_CYCLE:   return csr_cycle;
            S_INSTRET: return csr_instret;
            S_TIMER:   return csr_timer;
            S_TCMP:    return csr_timer_cmp;
            S_IRQ_REQ: return {47'd0, irq_req};
            S_IRQ_ID:  return {42'd0, irq_id};
            default:   return 48'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input int d, input sel_t s, input logic [47:0] v, input string n);
        exp_t e;
        e.due  = cyc + d;
        e.sel  = s;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    // Monitor: on each falling edge compare every entry due this cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    check(sb[i].name, peek(sb[i].sel), sb[i].val);
                    sb.delete(i);
                end else if (sb[i].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: never sampled, due %0d now %0d", sb[i].name, sb[i].due, cyc);
                    sb.delete(i);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [11:0] a, input logic [47:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic do_wr(input logic [11:0] a, input logic [47:0] d);
        set_wr(a, d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_trap(input logic [47:0] pc, input logic [47:0] cause, input logic ret);
        trap_valid = 1'b1;
        trap_pc    = pc;
        trap_cause = cause;
        trap_ret   = ret;
        step();
        trap_valid = 1'b0;
        trap_ret   = 1'b0;
    endtask

    task automatic pulse_ret();
        trap_ret = 1'b1;
        step();
        trap_ret = 1'b0;
    endtask

    task automatic expect_reset_state(input string tag);
        expect_at(0, S_PRIV,    48'd3, {tag, "_priv"});
        expect_at(0, S_STATUS,  48'd3, {tag, "_status"});  // [1:0] mirrors priv 3
        expect_at(0, S_SCRATCH, 48'd0, {tag, "_scratch"});
        expect_at(0, S_EPC,     48'd0, {tag, "_epc"});
        expect_at(0, S_EN,      48'd0, {tag, "_enable"});
        expect_at(0, S_PEND,    48'd0, {tag, "_pending"});
        expect_at(0, S_VEC,     RVEC,  {tag, "_vector"});
        expect_at(0, S_CYCLE,   48'd0, {tag, "_cycle"});
        expect_at(0, S_TCMP,    48'd0, {tag, "_timer_cmp"});
        expect_at(0, S_IRQ_REQ, 48'd0, {tag, "_irq_req"});
        expect_at(0, S_IRQ_ID,  48'd0, {tag, "_irq_id"});
    endtask

    logic timer_en;

    initial begin
`ifdef AMBER_CSR_TIMER_EN
        timer_en = 1'b1;
`else
        timer_en = 1'b0;
`endif
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        trap_valid  = 1'b0;
        trap_pc     = '0;
        trap_cause  = '0;
        trap_ret    = 1'b0;
        instret_inc = 1'b0;
        irq_lines   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, then 5 idle cycles.
        expect_reset_state("rst");
        expect_at(5, S_CYCLE,   48'd5, "idle_cycle");
        expect_at(5, S_TIMER,   timer_en ? 48'd5 : 48'd0, "idle_timer");
        expect_at(5, S_INSTRET, 48'd0, "idle_instret");
        expect_at(5, S_PRIV,    48'd3, "idle_priv");
        repeat (5) step();

        // Counter write wins, then wraps.
        expect_at(1, S_CYCLE, 48'hFFFF_FFFF_FFFF, "cycle_written");
        expect_at(2, S_CYCLE, 48'd0, "cycle_wrap");
        do_wr(12'hC00, 48'hFFFF_FFFF_FFFF);
        step();

        // Plain storage registers and an unmapped address.
        expect_at(1, S_SCRATCH, 48'hAA, "scratch_wr");
        do_wr(12'h001, 48'hAA);
        expect_at(1, S_LR, 48'h123, "lr_wr");
        do_wr(12'h004, 48'h123);
        expect_at(1, S_SSP, 48'h456, "ssp_wr");
        do_wr(12'h005, 48'h456);
        expect_at(1, S_VEC, 48'hABC, "vector_wr");
        do_wr(12'h012, 48'hABC);
        expect_at(1, S_SCRATCH, 48'hAA, "unmapped_scratch");
        expect_at(1, S_LR, 48'h123, "unmapped_lr");
        do_wr(12'h006, 48'h55);

        // Masked enable/pending writes.
        expect_at(1, S_EN, 48'h04, "enable_masked");
        do_wr(12'h010, 48'hF4);
        expect_at(1, S_PEND, 48'h01, "pending_masked");
        do_wr(12'h011, 48'hF1);
        expect_at(1, S_PEND, 48'h00, "pending_clr");
        do_wr(12'h011, 48'h00);
        expect_at(1, S_STATUS, 48'h07, "status_ie_priv3");
        do_wr(12'h000, 48'h04);

        // One-cycle line pulse: pending next cycle, irq_req one later.
        expect_at(1, S_PEND,    48'h04, "line_pending");
        expect_at(1, S_IRQ_REQ, 48'd0,  "irq_req_lag");
        expect_at(2, S_IRQ_REQ, 48'd1,  "irq_req_set");
        expect_at(2, S_IRQ_ID,  48'd2,  "irq_id");
        irq_lines = 48'h34;
        step();
        irq_lines = '0;
        step();

        // Hardware set beats software clear.
        expect_at(1, S_PEND, 48'h04, "hw_beats_sw");
        irq_lines = 48'h04;
        set_wr(12'h011, 48'h0);
        step();
        irq_lines = '0;
        wr_en     = 1'b0;
        expect_at(1, S_PEND,    48'h00, "pending_sw_clr");
        expect_at(2, S_IRQ_REQ, 48'd0,  "irq_req_clr");
        do_wr(12'h011, 48'h0);
        step();

        // Reach priv 0 via a trap return with PPRIV=0.
        expect_at(1, S_STATUS, 48'h03, "status_zero");
        do_wr(12'h000, 48'h00);
        expect_at(1, S_PRIV,   48'd0,  "ret_to_priv0");
        expect_at(1, S_STATUS, 48'h08, "ret_status");
        pulse_ret();
        expect_at(1, S_STATUS, 48'h04, "status_ie_priv0");
        do_wr(12'h000, 48'h04);
        expect_at(2, S_IRQ_REQ, 48'd1, "irq_req_pre_trap");
        irq_lines = 48'h04;
        step();
        irq_lines = '0;
        step();

        // Trap entry from priv 0 with IE=1.
        expect_at(1, S_EPC,     48'h1234, "trap_epc");
        expect_at(1, S_CAUSE,   48'd7,    "trap_cause");
        expect_at(1, S_STATUS,  48'h09,   "trap_status");
        expect_at(1, S_PRIV,    48'd1,    "trap_priv");
        expect_at(1, S_IRQ_REQ, 48'd1,    "irq_req_trap_lag");
        expect_at(2, S_IRQ_REQ, 48'd0,    "irq_req_trap_drop");
        pulse_trap(48'h1234, 48'd7, 1'b0);
        expect_at(1, S_STATUS, 48'h0C, "tret_status");
        expect_at(1, S_PRIV,   48'd0,  "tret_priv");
        pulse_ret();

        // Trap entry drops a same-cycle write.
        expect_at(1, S_SCRATCH, 48'hAA,   "trap_drops_wr");
        expect_at(1, S_EPC,     48'h5678, "trap2_epc");
        expect_at(1, S_STATUS,  48'h09,   "trap2_status");
        set_wr(12'h001, 48'hBB);
        pulse_trap(48'h5678, 48'd3, 1'b0);
        wr_en = 1'b0;

        // trap_valid and trap_ret together: entry only.
        expect_at(1, S_STATUS, 48'h11,   "both_status");
        expect_at(1, S_PRIV,   48'd1,    "both_priv");
        expect_at(1, S_EPC,    48'h9ABC, "both_epc");
        expect_at(1, S_CAUSE,  48'd5,    "both_cause");
        pulse_trap(48'h9ABC, 48'd5, 1'b1);

        // Trap return drops a status write but not other writes.
        expect_at(1, S_STATUS, 48'h09, "ret_drops_status_wr");
        expect_at(1, S_PRIV,   48'd1,  "ret_priv1");
        set_wr(12'h000, 48'hFF0);
        pulse_ret();
        wr_en = 1'b0;
        expect_at(1, S_SCRATCH, 48'hCC, "ret_keeps_scratch_wr");
        expect_at(1, S_STATUS,  48'h0C, "ret2_status");
        set_wr(12'h001, 48'hCC);
        pulse_ret();
        wr_en = 1'b0;

        // Retire counting and write-over-increment.
        expect_at(3, S_INSTRET, 48'd3, "instret_count");
        instret_inc = 1'b1;
        repeat (3) step();
        expect_at(1, S_INSTRET, 48'h100, "instret_wr_wins");
        expect_at(2, S_INSTRET, 48'h100, "instret_hold");
        do_wr(12'hC01, 48'h100);
        instret_inc = 1'b0;
        step();

        // Timer compare.
        expect_at(1, S_PEND, 48'h00, "pending_clr2");
        do_wr(12'h011, 48'h0);
        expect_at(1,  S_TIMER, 48'd0, "timer_wr");
        expect_at(2,  S_TCMP,  timer_en ? 48'd20 : 48'd0, "timer_cmp_wr");
        expect_at(21, S_TIMER, timer_en ? 48'd20 : 48'd0, "timer_at_cmp");
        expect_at(21, S_PEND,  48'h00, "timer_pend_before");
        expect_at(22, S_PEND,  timer_en ? (48'd1 << TBIT) : 48'h00, "timer_pend_set");
        do_wr(12'hC02, 48'd0);
        do_wr(12'hC03, 48'd20);
        repeat (22) step();

        // Reset in the middle of a write: nothing survives.
        set_wr(12'h001, 48'h99);
        rst = 1'b1;
        #1;
        expect_reset_state("midrst");
        step();
        wr_en = 1'b0;
        rst   = 1'b0;
        expect_at(1, S_SCRATCH, 48'd0, "post_rst_scratch");
        expect_at(1, S_PRIV,    48'd3, "post_rst_priv");
        repeat (3) step();

        if (sb.size() != 0) begin
            errors += sb.size();
            checks += sb.size();
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
